disk_bd_seq: RTL

DISK_BD_SEQ -- requirements
Module: disk_bd_seq

---
 rtl/disk_bd_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/disk_bd_seq.sv
// disk_bd_seq: sequences one host command (read / write / init) onto a
// block-device request/status interface and streams SECTOR_WORDS 16-bit
// words between host and device through a single-word read holding register.
// Optional build macro DISK_BD_SEQ_TIMEOUT_EN adds a TMO_CYCLES watchdog on
// the WBSY, WRDY and XFER wait states.
module disk_bd_seq #(
  parameter int unsigned SECTOR_WORDS = 256,
  parameter int unsigned TMO_CYCLES   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [23:0] req_addr,
  output logic        done,
  output logic        fail,
  output logic [15:0] rdw_data,
  output logic        rdw_valid,
  input  logic        rdw_ready,
  input  logic [15:0] wrw_data,
  input  logic        wrw_valid,
  output logic        wrw_ready,
  output logic [1:0]  bd_cmd,
  output logic        bd_start,
  output logic [23:0] bd_addr,
  output logic [15:0] bd_data_in,
  output logic        bd_rd,
  output logic        bd_wr,
  input  logic        bd_bsy,
  input  logic        bd_rdy,
  input  logic        bd_err,
  input  logic [15:0] bd_data_out,
  input  logic        bd_iordy
);

  typedef enum logic [2:0] {IDLE, WBSY, ISSUE, WRDY, XFER, DONE, FAIL} state_t;
  typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_INIT, CMD_RSVD} cmd_t;

  localparam int unsigned   CW       = $clog2(SECTOR_WORDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SECTOR_WORDS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SECTOR_WORDS);

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [23:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic          full_q, full_d;
  logic          pend_q, pend_d;   // bd_rd issued last cycle, data arrives now
  logic          drain;

`ifdef DISK_BD_SEQ_TIMEOUT_EN
  logic [31:0]   tmo_q, tmo_d;
`else
  // TMO_CYCLES has no effect unless the watchdog is built in
  if (TMO_CYCLES == 0) begin : g_tmo_unused
  end
`endif

  assign bd_cmd     = cmd_q;
  assign bd_addr    = addr_q;
  assign rdw_valid  = full_q;
  assign rdw_data   = full_q ? hold_q : '0;
  assign bd_data_in = bd_wr ? wrw_data : '0;
  assign drain      = full_q & rdw_ready;

  // Next-state, strobes and datapath updates
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    full_d    = full_q;
    pend_d    = 1'b0;
    req_ready = 1'b0;
    bd_start  = 1'b0;
    bd_rd     = 1'b0;
    bd_wr     = 1'b0;
    wrw_ready = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;

    if (drain) full_d = 1'b0;
    if (pend_q) begin
      hold_d = bd_data_out;
      full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_d   = cmd_t'(req_cmd);
          addr_d  = req_addr;
          cnt_d   = '0;
          state_d = (cmd_t'(req_cmd) == CMD_RSVD) ? FAIL : WBSY;
        end
      end
      WBSY:  if (!bd_bsy) state_d = ISSUE;
      ISSUE: begin
        bd_start = 1'b1;
        state_d  = WRDY;
      end
      WRDY:  if (bd_rdy) state_d = (cmd_q == CMD_INIT) ? DONE : XFER;
      XFER: begin
        if (cmd_q == CMD_READ) begin
          // A read in flight blocks the next one: its word lands next cycle
          // and the holding register has room for only that one.
          if (bd_iordy && cnt_q != CNT_FULL && !pend_q && (!full_q || drain)) begin
            bd_rd  = 1'b1;
            pend_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
          if (cnt_q == CNT_FULL && !pend_q && (!full_q || drain)) state_d = DONE;
        end else begin
          wrw_ready = bd_iordy && (cnt_q != CNT_FULL);
          if (wrw_valid && wrw_ready) begin
            bd_wr = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        fail    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bd_err && (state_q inside {WBSY, ISSUE, WRDY, XFER})) state_d = FAIL;

`ifdef DISK_BD_SEQ_TIMEOUT_EN
    if ((state_q inside {WBSY, WRDY, XFER}) && state_d == state_q && !bd_rd && !bd_wr &&
        tmo_q == 32'(TMO_CYCLES - 1))
      state_d = FAIL;
    tmo_d = (state_d != state_q || bd_rd || bd_wr) ? '0 : tmo_q + 32'd1;
`endif

    // Leaving for FAIL discards any word still held or in flight
    if (state_d == FAIL) begin
      full_d = 1'b0;
      pend_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= CMD_READ;
      addr_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
`ifdef DISK_BD_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
`ifdef DISK_BD_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule
